// File: rtl/trace_ram_ctrl.sv
// trace_ram_ctrl
//   Write-port sequencer for the 80x30 tile RAM of the Etch-A-Sketch display.
//   It owns the cursor and turns encoder step ticks into cursor moves.
//   When tracing is enabled, it writes DOT_CODE at each new cursor tile.
//   On clear_req it sweeps BLANK_CODE over every tile, then re-inks the
//   cursor tile.
//   Build option: define CURSOR_WRAP_EN to make the cursor wrap at the screen
//   edges. By default the cursor saturates at the edges.
// Ports
//   clk_100MHz  in   system clock
//   reset       in   asynchronous active-high reset
//   trace_en    in   1: moves leave ink
//   step_*      in   one-cycle move ticks (up/down/left/right)
//   clear_req   in   one-cycle tick, start erase sweep
//   we/addr_w/din   out  RAM port A write enable, address {y,x}, data
//   cur_x/cur_y     out  cursor position
//   busy        out  sweep or restore in progress
//   clear_done  out  one-cycle pulse after restore
module trace_ram_ctrl #(
    parameter int unsigned MAX_X      = 80,
    parameter int unsigned MAX_Y      = 30,
    parameter int unsigned START_X    = 40,
    parameter int unsigned START_Y    = 15,
    parameter logic [6:0]  DOT_CODE   = 7'h01,
    parameter logic [6:0]  BLANK_CODE = 7'h00
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        trace_en,
    input  logic        step_up,
    input  logic        step_down,
    input  logic        step_left,
    input  logic        step_right,
    input  logic        clear_req,
    output logic        we,
    output logic [11:0] addr_w,
    output logic [6:0]  din,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        busy,
    output logic        clear_done
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RESTORE} state_t;

    state_t      r_state, w_state_n;
    logic [6:0]  r_x, w_x_n, r_sx, w_sx_n;
    logic [4:0]  r_y, w_y_n, r_sy, w_sy_n;
    logic        r_we, w_we_n, r_busy, w_busy_n, r_done, w_done_n;
    logic [11:0] r_addr, w_addr_n;
    logic [6:0]  r_din, w_din_n;

    logic       w_xp, w_xn, w_yp, w_yn;
    logic       w_mx, w_my;
    logic [6:0] w_nx;
    logic [4:0] w_ny;

    localparam logic [6:0] XMAX = 7'(MAX_X - 1);
    localparam logic [4:0] YMAX = 5'(MAX_Y - 1);

    // Opposite ticks on one axis cancel. Positive Y is downward.
    assign w_xp = step_right & ~step_left;
    assign w_xn = step_left  & ~step_right;
    assign w_yp = step_down  & ~step_up;
    assign w_yn = step_up    & ~step_down;

    always_comb begin
        w_mx = 1'b0;
        w_my = 1'b0;
        w_nx = r_x;
        w_ny = r_y;
`ifdef CURSOR_WRAP_EN
        if (w_xp) begin
            w_mx = 1'b1;
            w_nx = (r_x == XMAX) ? '0 : r_x + 7'd1;
        end else if (w_xn) begin
            w_mx = 1'b1;
            w_nx = (r_x == '0) ? XMAX : r_x - 7'd1;
        end
        if (w_yp) begin
            w_my = 1'b1;
            w_ny = (r_y == YMAX) ? '0 : r_y + 5'd1;
        end else if (w_yn) begin
            w_my = 1'b1;
            w_ny = (r_y == '0) ? YMAX : r_y - 5'd1;
        end
`else
        // A move blocked at an edge counts as no move on that axis.
        if (w_xp && r_x != XMAX) begin
            w_mx = 1'b1;
            w_nx = r_x + 7'd1;
        end else if (w_xn && r_x != '0) begin
            w_mx = 1'b1;
            w_nx = r_x - 7'd1;
        end
        if (w_yp && r_y != YMAX) begin
            w_my = 1'b1;
            w_ny = r_y + 5'd1;
        end else if (w_yn && r_y != '0) begin
            w_my = 1'b1;
            w_ny = r_y - 5'd1;
        end
`endif
    end

    always_comb begin
        w_state_n = r_state;
        w_x_n     = r_x;
        w_y_n     = r_y;
        w_sx_n    = r_sx;
        w_sy_n    = r_sy;
        w_we_n    = 1'b0;
        w_addr_n  = r_addr;
        w_din_n   = r_din;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clear_req) begin
                    // The first sweep write, at tile (0,0), starts next cycle.
                    w_state_n = S_CLEAR;
                    w_sx_n    = '0;
                    w_sy_n    = '0;
                    w_we_n    = 1'b1;
                    w_addr_n  = '0;
                    w_din_n   = BLANK_CODE;
                    w_busy_n  = 1'b1;
                end else if (w_mx || w_my) begin
                    w_x_n = w_nx;
                    w_y_n = w_ny;
                    if (trace_en) begin
                        w_we_n   = 1'b1;
                        w_addr_n = {w_ny, w_nx};
                        w_din_n  = DOT_CODE;
                    end
                end
            end
            S_CLEAR: begin
                // r_sx/r_sy hold the tile being written this cycle.
                if (r_sx == XMAX && r_sy == YMAX) begin
                    w_state_n = S_RESTORE;
                    w_we_n    = trace_en;
                    w_addr_n  = {r_y, r_x};
                    w_din_n   = DOT_CODE;
                end else begin
                    if (r_sx == XMAX) begin
                        w_sx_n = '0;
                        w_sy_n = r_sy + 5'd1;
                    end else begin
                        w_sx_n = r_sx + 7'd1;
                    end
                    w_we_n   = 1'b1;
                    w_addr_n = {w_sy_n, w_sx_n};
                    w_din_n  = BLANK_CODE;
                end
            end
            S_RESTORE: begin
                w_state_n = S_IDLE;
                w_sx_n    = '0;
                w_sy_n    = '0;
                w_busy_n  = 1'b0;
                w_done_n  = 1'b1;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x     <= 7'(START_X);
            r_y     <= 5'(START_Y);
            r_sx    <= '0;
            r_sy    <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_x     <= w_x_n;
            r_y     <= w_y_n;
            r_sx    <= w_sx_n;
            r_sy    <= w_sy_n;
            r_we    <= w_we_n;
            r_addr  <= w_addr_n;
            r_din   <= w_din_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    assign we         = r_we;
    assign addr_w     = r_addr;
    assign din        = r_din;
    assign cur_x      = r_x;
    assign cur_y      = r_y;
    assign busy       = r_busy;
    assign clear_done = r_done;

endmodule

// File: tb/tb_trace_ram_ctrl.sv
module tb_trace_ram_ctrl;

    logic        clk_100MHz = 1'b0;
    logic        reset = 1'b0;
    logic        trace_en = 1'b0;
    logic        step_up = 1'b0, step_down = 1'b0, step_left = 1'b0, step_right = 1'b0;
    logic        clear_req = 1'b0;
    logic        we;
    logic [11:0] addr_w;
    logic [6:0]  din;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;
    logic        clear_done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_sw     = 0;   // blank writes seen while busy
    int n_done   = 0;   // clear_done pulses seen

    trace_ram_ctrl dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .trace_en(trace_en),
        .step_up(step_up), .step_down(step_down), .step_left(step_left),
        .step_right(step_right), .clear_req(clear_req),
        .we(we), .addr_w(addr_w), .din(din), .cur_x(cur_x), .cur_y(cur_y),
        .busy(busy), .clear_done(clear_done)
    );

    initial forever #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model. Phase 0 is idle, phase 1 is the sweep at write
    // index m_k, and phase 2 is restore.
    int          m_x = 40, m_y = 15, m_phase = 0, m_k = 0;
    logic        e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    logic [11:0] e_addr = '0;
    logic [6:0]  e_din = '0;

    function automatic logic [11:0] tile(input int x, input int y);
        return 12'(y * 128 + x);
    endfunction

    initial begin
        int dx, dy, nx, ny;
        forever begin
            @(posedge clk_100MHz or posedge reset);
            if (reset) begin
                m_x = 40; m_y = 15; m_phase = 0; m_k = 0;
                e_we = 0; e_addr = '0; e_din = '0; e_busy = 0; e_done = 0;
            end else if (m_phase == 0) begin
                e_done = 0;
                e_we = 0;
                if (clear_req) begin
                    m_phase = 1; m_k = 0;
                    e_we = 1; e_addr = tile(0, 0); e_din = 7'h00; e_busy = 1;
                end else begin
                    dx = int'(step_right) - int'(step_left);
                    dy = int'(step_down) - int'(step_up);
`ifdef CURSOR_WRAP_EN
                    nx = (m_x + dx + 80) % 80;
                    ny = (m_y + dy + 30) % 30;
`else
                    nx = m_x + dx; if (nx < 0) nx = 0; if (nx > 79) nx = 79;
                    ny = m_y + dy; if (ny < 0) ny = 0; if (ny > 29) ny = 29;
`endif
                    if (trace_en && (nx != m_x || ny != m_y)) begin
                        e_we = 1; e_addr = tile(nx, ny); e_din = 7'h01;
                    end
                    m_x = nx; m_y = ny;
                end
            end else if (m_phase == 1) begin
                if (m_k == 2399) begin
                    m_phase = 2;
                    e_we = trace_en; e_addr = tile(m_x, m_y); e_din = 7'h01;
                end else begin
                    m_k++;
                    e_we = 1; e_addr = tile(m_k % 80, m_k / 80); e_din = 7'h00;
                end
            end else begin
                m_phase = 0; e_we = 0; e_busy = 0; e_done = 1;
            end
        end
    end

    // Compare process: checks every cycle; address and data only during writes.
    initial forever begin
        @(negedge clk_100MHz);
        check("cur_x", 32'(cur_x), 32'(m_x));
        check("cur_y", 32'(cur_y), 32'(m_y));
        check("we", 32'(we), 32'(e_we));
        check("busy", 32'(busy), 32'(e_busy));
        check("clear_done", 32'(clear_done), 32'(e_done));
        if (e_we) begin
            check("addr_w", 32'(addr_w), 32'(e_addr));
            check("din", 32'(din), 32'(e_din));
        end
    end

    initial forever begin
        @(negedge clk_100MHz);
        if (we === 1'b1 && busy === 1'b1 && din === 7'h00) n_sw++;
        if (clear_done === 1'b1) n_done++;
    end

    task automatic nclk;
        @(negedge clk_100MHz);
        #2;
    endtask

    task automatic tick(input logic u, input logic d, input logic l, input logic r, input logic c);
        step_up = u; step_down = d; step_left = l; step_right = r; clear_req = c;
        nclk();
        step_up = 0; step_down = 0; step_left = 0; step_right = 0; clear_req = 0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (n_done != 0) break;
            nclk();
        end
        check(name, 32'(n_done != 0), 32'd1);
    endtask

    logic [11:0] t1_addr [3] = '{12'h7A9, 12'h7AA, 12'h7AB};

    initial begin
        logic [6:0] x_before;
        #1 reset = 1'b1;
        repeat (3) nclk();
        reset = 1'b0;
        nclk();
        check("reset_x", 32'(cur_x), 32'd40);
        check("reset_y", 32'(cur_y), 32'd15);
        check("reset_we", 32'(we), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // 1: traced moves to the right
        trace_en = 1;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 1, 0);
            check("t1_x", 32'(cur_x), 32'(41 + i));
            check("t1_we", 32'(we), 32'd1);
            check("t1_addr", 32'(addr_w), 32'(t1_addr[i]));
            check("t1_din", 32'(din), 32'h01);
        end

        // 2: untraced move, then cancelling ticks
        trace_en = 0;
        tick(1, 0, 0, 0, 0);
        check("t2_y", 32'(cur_y), 32'd14);
        check("t2_we", 32'(we), 32'd0);
        tick(1, 1, 0, 0, 0);
        check("t2_cancel_y", 32'(cur_y), 32'd14);
        check("t2_cancel_we", 32'(we), 32'd0);

        // 3: left edge
        for (int i = 0; i < 43; i++) tick(0, 0, 1, 0, 0);
        check("t3_at0", 32'(cur_x), 32'd0);
        trace_en = 1;
        tick(0, 0, 1, 0, 0);
`ifdef CURSOR_WRAP_EN
        check("t3_wrap_x", 32'(cur_x), 32'd79);
        check("t3_wrap_addr", 32'(addr_w), 32'h74F);
        tick(0, 0, 0, 1, 0);
`else
        check("t3_sat_x", 32'(cur_x), 32'd0);
        check("t3_sat_we", 32'(we), 32'd0);
`endif
        // diagonal move
        tick(0, 1, 0, 1, 0);
        check("t3_diag_x", 32'(cur_x), 32'd1);
        check("t3_diag_y", 32'(cur_y), 32'd15);
        // top edge
        trace_en = 0;
        for (int i = 0; i < 15; i++) tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
`ifdef CURSOR_WRAP_EN
        check("t3_top_y", 32'(cur_y), 32'd29);
        tick(0, 1, 0, 0, 0);
`else
        check("t3_top_y", 32'(cur_y), 32'd0);
`endif

        // 4/5: clear and step in the same cycle, steps and clear_req during the sweep
        trace_en = 1;
        x_before = cur_x;
        n_sw = 0; n_done = 0;
        tick(0, 0, 0, 1, 1);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_first_addr", 32'(addr_w), 32'd0);
        check("t5_first_din", 32'(din), 32'd0);
        check("t5_x_frozen", 32'(cur_x), 32'(x_before));
        for (int i = 0; i < 20; i++) tick(0, 1, 0, 1, 0);
        repeat (400) nclk();
        tick(0, 0, 0, 0, 1);
        wait_done("t4_done_timeout");
        repeat (5) nclk();
        check("t4_sweep_writes", 32'(n_sw), 32'd2400);
        check("t4_done_pulses", 32'(n_done), 32'd1);
        check("t4_x_after", 32'(cur_x), 32'(x_before));

        // 6: reset mid-sweep
        n_sw = 0; n_done = 0;
        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            if (n_sw >= 1000) break;
            nclk();
        end
        check("t6_reach_1000", 32'(n_sw >= 1000), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_we", 32'(we), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_addr", 32'(addr_w), 32'd0);
        check("t6_rst_x", 32'(cur_x), 32'd40);
        check("t6_rst_y", 32'(cur_y), 32'd15);
        repeat (2) nclk();
        reset = 1'b0;
        repeat (2500) nclk();
        check("t6_no_done", 32'(n_done), 32'd0);
        n_sw = 0;
        tick(0, 0, 0, 0, 1);
        wait_done("t6_done_timeout");
        repeat (3) nclk();
        check("t6_full_sweep", 32'(n_sw), 32'd2400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
